// File: rtl/conv_pkg.sv
// Shared constants, kernel-mode encoding and window helpers for the 3x3 filter stage.
package conv_pkg;

    localparam int PIX_W = 12;
    localparam int CH_W  = 4;
    localparam int WIN_N = 9;
    localparam int WIN_W = WIN_N * PIX_W;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_GAUSS = 2'd1,
        MODE_SHARP = 2'd2,
        MODE_SOBEL = 2'd3
    } mode_e;

    // Element k = 3*row + col; channel 0 = B, 1 = G, 2 = R.
    function automatic logic [CH_W-1:0] win_elem(
        input logic [WIN_W-1:0] win,
        input int               k,
        input int               ch
    );
        return win[k*PIX_W + ch*CH_W +: CH_W];
    endfunction

    // a + 2b + c, the 1-2-1 weighting shared by the blur rows and Sobel edges.
    function automatic logic [5:0] wsum3(
        input logic [CH_W-1:0] a,
        input logic [CH_W-1:0] b,
        input logic [CH_W-1:0] c
    );
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

endpackage

// File: rtl/conv3x3_stage_if.sv
// Window-in / pixel-out handshake bundle for conv3x3_stage.
interface conv3x3_stage_if #(
    parameter int PIX_W = 12
) ();

    logic               in_valid;
    logic               in_ready;
    logic [9*PIX_W-1:0] win;
    logic [1:0]         in_mode;
    logic               in_sof;
    logic               in_eol;

    logic               out_valid;
    logic               out_ready;
    logic [PIX_W-1:0]   out_pix;
    logic               out_sof;
    logic               out_eol;

    modport slave (
        input  in_valid, win, in_mode, in_sof, in_eol, out_ready,
        output in_ready, out_valid, out_pix, out_sof, out_eol
    );

    modport master (
        output in_valid, win, in_mode, in_sof, in_eol, out_ready,
        input  in_ready, out_valid, out_pix, out_sof, out_eol
    );

endinterface

// File: rtl/conv_channel.sv
// Three-stage kernel arithmetic for one 4-bit colour channel; the stall enable and the
// mode of the window in S2 come from the shared control pipeline in the top level.
module conv_channel
    import conv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [CH_W-1:0] c [WIN_N],
    input  mode_e           mode_s2,
    output logic [CH_W-1:0] res
);

    // S1: weighted rows/columns and sharpen terms
    logic [CH_W-1:0] c4_s1_reg;
    logic [5:0]      row0_s1_reg;
    logic [5:0]      row1_s1_reg;
    logic [5:0]      row2_s1_reg;
    logic [5:0]      col0_s1_reg;
    logic [5:0]      col2_s1_reg;
    logic [6:0]      p5_s1_reg;
    logic [5:0]      n4_s1_reg;

    // S2: totals and Sobel magnitudes
    logic [CH_W-1:0]   c4_s2_reg;
    logic [7:0]        gsum_s2_reg;
    logic signed [7:0] sharp_s2_reg;
    logic [5:0]        ax_s2_reg;
    logic [5:0]        ay_s2_reg;

    logic [6:0]      gx_next;
    logic [6:0]      gy_next;
    logic [7:0]      g_rnd;
    logic [6:0]      m_sum;
    logic [6:0]      m_q;
    logic [CH_W-1:0] res_next;
    logic [CH_W-1:0] res_reg;

    function automatic logic [5:0] abs7(input logic [6:0] v);
        return 6'(v[6] ? (7'd0 - v) : v);
    endfunction

    // Gx pairs the weighted right/left columns, Gy the bottom/top rows.
    assign gx_next = {1'b0, col2_s1_reg} - {1'b0, col0_s1_reg};
    assign gy_next = {1'b0, row2_s1_reg} - {1'b0, row0_s1_reg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c4_s1_reg    <= '0;
            row0_s1_reg  <= '0;
            row1_s1_reg  <= '0;
            row2_s1_reg  <= '0;
            col0_s1_reg  <= '0;
            col2_s1_reg  <= '0;
            p5_s1_reg    <= '0;
            n4_s1_reg    <= '0;
            c4_s2_reg    <= '0;
            gsum_s2_reg  <= '0;
            sharp_s2_reg <= '0;
            ax_s2_reg    <= '0;
            ay_s2_reg    <= '0;
            res_reg      <= '0;
        end else if (en) begin
            c4_s1_reg    <= c[4];
            row0_s1_reg  <= wsum3(c[0], c[1], c[2]);
            row1_s1_reg  <= wsum3(c[3], c[4], c[5]);
            row2_s1_reg  <= wsum3(c[6], c[7], c[8]);
            col0_s1_reg  <= wsum3(c[0], c[3], c[6]);
            col2_s1_reg  <= wsum3(c[2], c[5], c[8]);
            p5_s1_reg    <= {3'b000, c[4]} + {1'b0, c[4], 2'b00};
            n4_s1_reg    <= {2'b00, c[1]} + {2'b00, c[3]} + {2'b00, c[5]} + {2'b00, c[7]};

            c4_s2_reg    <= c4_s1_reg;
            gsum_s2_reg  <= {2'b00, row0_s1_reg} + {1'b0, row1_s1_reg, 1'b0} + {2'b00, row2_s1_reg};
            sharp_s2_reg <= $signed({1'b0, p5_s1_reg}) - $signed({2'b00, n4_s1_reg});
            ax_s2_reg    <= abs7(gx_next);
            ay_s2_reg    <= abs7(gy_next);

            res_reg      <= res_next;
        end
    end

    // S3: gsum tops out at 240, so the rounded value already fits in four bits.
    always_comb begin
        res_next = '0;
        g_rnd    = gsum_s2_reg + 8'd8;
        m_sum    = {1'b0, ax_s2_reg} + {1'b0, ay_s2_reg};
        m_q      = m_sum >> 2;
        case (mode_s2)
            MODE_PASS:  res_next = c4_s2_reg;
            MODE_GAUSS: res_next = 4'(g_rnd >> 4);
            MODE_SHARP: begin
                if (sharp_s2_reg < 8'sd0)
                    res_next = '0;
                else if (sharp_s2_reg > 8'sd15)
                    res_next = 4'hF;
                else
                    res_next = 4'(sharp_s2_reg);
            end
            MODE_SOBEL: res_next = (m_q > 7'd15) ? 4'hF : 4'(m_q);
            default:    res_next = '0;
        endcase
    end

    assign res = res_reg;

endmodule

// File: rtl/conv3x3_stage.sv
// Pipelined 3x3 RGB444 kernel filter: shared valid/mode/sideband pipeline and
// handshake, with one conv_channel per colour channel.
module conv3x3_stage #(
    parameter int PIX_W = 12,
    parameter int CH_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    conv3x3_stage_if.slave bus
);
    import conv_pkg::mode_e;
    import conv_pkg::MODE_PASS;
    import conv_pkg::WIN_N;
    import conv_pkg::win_elem;

    logic            advance;
    logic            v1_reg;
    logic            v2_reg;
    logic            ov_reg;
    mode_e           mode1_reg;
    mode_e           mode2_reg;
    logic            sof1_reg;
    logic            sof2_reg;
    logic            sof3_reg;
    logic            eol1_reg;
    logic            eol2_reg;
    logic            eol3_reg;
    logic [CH_W-1:0] ch_res [3];
    logic [PIX_W-1:0] pix_w;

    // Whole pipeline moves as one; bubbles are kept so timing stays fixed.
    assign advance      = !ov_reg || bus.out_ready;
    assign bus.in_ready = advance;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
            ov_reg    <= 1'b0;
            mode1_reg <= MODE_PASS;
            mode2_reg <= MODE_PASS;
            sof1_reg  <= 1'b0;
            sof2_reg  <= 1'b0;
            sof3_reg  <= 1'b0;
            eol1_reg  <= 1'b0;
            eol2_reg  <= 1'b0;
            eol3_reg  <= 1'b0;
        end else if (advance) begin
            v1_reg    <= bus.in_valid;
            v2_reg    <= v1_reg;
            ov_reg    <= v2_reg;
            mode1_reg <= mode_e'(bus.in_mode);
            mode2_reg <= mode1_reg;
            sof1_reg  <= bus.in_valid & bus.in_sof;
            sof2_reg  <= sof1_reg;
            sof3_reg  <= sof2_reg;
            eol1_reg  <= bus.in_valid & bus.in_eol;
            eol2_reg  <= eol1_reg;
            eol3_reg  <= eol2_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            logic [CH_W-1:0] elem [WIN_N];
            for (genvar gj = 0; gj < WIN_N; gj++) begin : g_elem
                assign elem[gj] = win_elem(bus.win, gj, gi);
            end
            conv_channel u_ch (
                .clk     (clk),
                .rst     (rst),
                .en      (advance),
                .c       (elem),
                .mode_s2 (mode2_reg),
                .res     (ch_res[gi])
            );
        end
    endgenerate

    assign pix_w         = {ch_res[2], ch_res[1], ch_res[0]};
    assign bus.out_pix   = pix_w;
    assign bus.out_valid = ov_reg;
    assign bus.out_sof   = sof3_reg;
    assign bus.out_eol   = eol3_reg;

endmodule

// File: tb/tb_conv3x3_stage.sv
// Directed scoreboard bench for conv3x3_stage: stimulus pushes hand-computed results,
// a negedge monitor pops and compares every retired pixel.
module tb_conv3x3_stage;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv3x3_stage_if #(.PIX_W(12)) bus ();

    conv3x3_stage #(.PIX_W(12), .CH_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [11:0] pix;
        logic        sof;
        logic        eol;
        int          acc_cyc;
        bit          lat_chk;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_out = 0;

    logic [107:0] wa, wb;
    logic [107:0] s_win [10];
    logic [11:0]  s_exp [10] = '{12'h550, 12'h355, 12'h550, 12'h0F0, 12'hA37,
                                 12'h554, 12'hF0F, 12'h88F, 12'h550, 12'h355};
    bit   [9:0]   s_use_b = 10'b1001011010;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [107:0] mkwin(
        input logic [11:0] p0, input logic [11:0] p1, input logic [11:0] p2,
        input logic [11:0] p3, input logic [11:0] p4, input logic [11:0] p5,
        input logic [11:0] p6, input logic [11:0] p7, input logic [11:0] p8
    );
        return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
    endfunction

    function automatic logic [107:0] uni(input logic [11:0] centre, input logic [11:0] other);
        return mkwin(other, other, other, other, centre, other, other, other, other);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic send(input logic [107:0] w, input logic [1:0] m, input logic sof,
                        input logic eol, input logic [11:0] req_pix, input bit lat);
        bit   done = 1'b0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.win      = w;
        bus.in_mode  = m;
        bus.in_sof   = sof;
        bus.in_eol   = eol;
        for (int g = 0; g < 100 && !done; g++) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 required 1");
        end else begin
            e.pix     = req_pix;
            e.sof     = sof;
            e.eol     = eol;
            e.acc_cyc = cyc;
            e.lat_chk = lat;
            exp_q.push_back(e);
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eol   = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int g = 0; g < 50 && exp_q.size() != 0; g++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    // Monitor: retire on valid&&ready, check hold against the queue head while stalled.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got pix=%h required none", bus.out_pix);
            end else if (bus.out_ready) begin
                e = exp_q.pop_front();
                n_out++;
                $display("out #%0d pix=%h sof=%b eol=%b exp=%h", n_out, bus.out_pix,
                         bus.out_sof, bus.out_eol, e.pix);
                check("out_pix", bus.out_pix, e.pix);
                check("out_side", {bus.out_sof, bus.out_eol}, {e.sof, e.eol});
                if (e.lat_chk) check("latency", cyc - e.acc_cyc, 2);
            end else begin
                check("hold_pix", bus.out_pix, exp_q[0].pix);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic seen;
        bus.in_valid  = 1'b0;
        bus.win       = '0;
        bus.in_mode   = 2'd0;
        bus.in_sof    = 1'b0;
        bus.in_eol    = 1'b0;
        bus.out_ready = 1'b1;

        wa = mkwin(12'h190, 12'h280, 12'h37F, 12'h460, 12'h550, 12'h64F, 12'h730, 12'h820, 12'h91F);
        wb = mkwin(12'h1F2, 12'h1F4, 12'h1F6, 12'h108, 12'hA37, 12'h103, 12'h105, 12'h101, 12'h109);
        for (int i = 0; i < 10; i++) s_win[i] = s_use_b[i] ? wb : wa;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_pix", bus.out_pix, 0);
        check("rst_side", {bus.out_sof, bus.out_eol}, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Flat Gaussian, single-cycle output pulse
        send(uni(12'h888, 12'h888), 2'd1, 1'b0, 1'b0, 12'h888, 1'b1);
        @(negedge clk);
        check("flat_not_yet_0", bus.out_valid, 0);
        @(negedge clk);
        check("flat_not_yet_1", bus.out_valid, 0);
        @(negedge clk);
        check("flat_valid", bus.out_valid, 1);
        @(negedge clk);
        check("flat_pulse_end", bus.out_valid, 0);
        @(posedge clk);
        #1;

        // Sharpen clamps, Sobel saturation, pass-through
        send(uni(12'hF00, 12'h000), 2'd2, 1'b0, 1'b0, 12'hF00, 1'b1);
        send(uni(12'h000, 12'hF00), 2'd2, 1'b0, 1'b0, 12'h000, 1'b1);
        send(mkwin(12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'hFFF),
             2'd3, 1'b0, 1'b0, 12'hFFF, 1'b1);
        send(mkwin(12'h123, 12'h456, 12'h789, 12'hABC, 12'h5E1, 12'hDEF, 12'h321, 12'h654, 12'h987),
             2'd0, 1'b0, 1'b1, 12'h5E1, 1'b1);
        drain("drain_directed");

        // Back-to-back mixed-mode stream
        for (int i = 0; i < 10; i++)
            send(s_win[i], 2'(i % 4), (i == 0), (i == 4 || i == 9), s_exp[i], 1'b1);
        drain("drain_stream");

        // Backpressure mid-stream
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(s_win[i], 2'(i % 4), (i == 0), 1'b0, s_exp[i], 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                check("bp_out_valid", bus.out_valid, 1);
                check("bp_in_ready", bus.in_ready, 0);
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("drain_bp");

        // Reset with windows in flight
        send(wa, 2'd0, 1'b0, 1'b0, 12'h550, 1'b0);
        send(wb, 2'd1, 1'b0, 1'b0, 12'h355, 1'b0);
        send(wa, 2'd3, 1'b0, 1'b0, 12'h88F, 1'b0);
        check("mid_pre_valid", bus.out_valid, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_pix", bus.out_pix, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | bus.out_valid;
        end
        check("mid_no_stale", seen, 0);
        @(posedge clk);
        #1;
        send(wb, 2'd2, 1'b0, 1'b0, 12'hF0F, 1'b1);
        drain("drain_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv3x3_stage.md
# conv3x3_stage

Pipelined 3×3 kernel filter that consumes the 108-bit nine-pixel window produced by the line-buffer slice and emits one filtered RGB444 pixel per window. It processes the R, G and B 4-bit channels independently. The kernel is selectable per window: pass-through, Gaussian blur, sharpen or Sobel edge magnitude. It sits between the window buffer and the frame-buffer/VGA write path, and applies valid/ready backpressure upstream.

## Interface
Parameters:
- PIX_W, 12: pixel width, {R[11:8], G[7:4], B[3:0]}.
- CH_W, 4: channel width.

Ports:
- clk, input, 1: sole clock; all logic on the rising edge.
- rst, input, 1: reset, asynchronous, active-low; asserted when 0.
- in_valid, input, 1: window and sideband valid.
- in_ready, output, 1: stage accepts the window this cycle.
- win, input, 9*PIX_W: window; element k = win[12k +: 12], k = 3·row + col, row 0 = top, col 0 = left, k=4 = centre.
- in_mode, input, 2: kernel select, captured with the window.
- in_sof, input, 1: start-of-frame flag, carried alongside the window.
- in_eol, input, 1: end-of-line flag, carried alongside the window.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts the result.
- out_pix, output, PIX_W: filtered pixel.
- out_sof, output, 1: delayed in_sof, aligned with out_pix.
- out_eol, output, 1: delayed in_eol, aligned with out_pix.

## Operation
- Accept: a window is accepted when in_valid && in_ready. The combinational signal in_ready = !out_valid || out_ready.
- Advance: the pipeline advances only when in_ready = 1. When it stalls, every stage holds, including bubbles. Bubbles are not collapsed.
- Mode capture: mode and sideband travel with their window. A mode change affects only windows accepted after the change.
- Per-channel kernels (c_k = channel value of element k, unsigned 0..15):
  - mode 0, pass-through: out = c4.
  - mode 1, Gaussian: s = (c0+c2+c6+c8) + 2(c1+c3+c5+c7) + 4c4. s is 8-bit unsigned with max 240. out = (s+8)>>4. The result never exceeds 15.
  - mode 2, sharpen: s = 5c4 − c1 − c3 − c5 − c7. s is 8-bit signed with range −60..75. out = clamp(s, 0, 15).
  - mode 3, Sobel: Gx = (c2+2c5+c8) − (c0+2c3+c6) and Gy = (c6+2c7+c8) − (c0+2c1+c2), each 7-bit signed in ±60. m = |Gx|+|Gy|, max 120. out = min(15, m>>2).
- Arithmetic: all intermediate values are sized to avoid overflow. Truncation happens only at the final clamp.

## Timing
- Pipeline stages:
  - S1: row partial sums and Sobel partial terms.
  - S2: total sum or Gx/Gy, and absolute values.
  - S3: round, clamp and output register.
- Latency: 3 rising edges, with the acceptance edge counted as the first. A window accepted at edge N presents out_valid = 1 after edge N+2 when there is no stall.
- Throughput: 1 window per cycle while out_ready = 1.
- Output hold: out_pix, out_sof and out_eol are stable while out_valid && !out_ready.
- Reset values: every stage valid bit, out_valid, out_pix, out_sof and out_eol are 0. in_ready is 1 during and after reset.
- Reset mid-stream: in-flight windows are discarded immediately, asynchronously. Nothing is emitted for them after release.
- Simultaneous accept and emit: when out_valid && out_ready && in_valid, the new window enters S1 on the same edge the output retires.

## Structure
- Shared package conv_pkg holds:
  - PIX_W, CH_W and WIN_N = 9.
  - Mode constants MODE_PASS=0, MODE_GAUSS=1, MODE_SHARP=2 and MODE_SOBEL=3.
  - A window-element extract function (k, channel) → 4-bit value.
- One sub-module, conv_channel, implements the three-stage arithmetic for a single 4-bit channel. It is instantiated three times.
- Valid, mode and sideband pipeline registers plus the handshake live in the top level, shared across channels.

## Test plan
- Gaussian on a flat window: all nine pixels 12'h888, mode 1, out_ready = 1 → out_pix = 12'h888 three edges after acceptance, out_valid high for exactly one cycle.
- Sharpen with clamping:
  - centre 12'hF00, others 12'h000, mode 2 → 12'hF00.
  - centre 12'h000, neighbours 12'hF00, mode 2 → 12'h000.
- Sobel and pass-through:
  - columns 0 and 1 = 12'h000, column 2 = 12'hFFF, mode 3 → Gx = 60 per channel, out = 12'hFFF.
  - any window in mode 0 → its centre pixel.
- Streaming with mixed modes and sideband: 10 back-to-back windows with modes 0,1,2,3 repeating and in_sof on the first window → results in order, one per cycle, out_sof only on the first result.
- Backpressure: stream 6 windows, hold out_ready = 0 for 4 cycles mid-stream → in_ready drops, out_pix stays stable, no window is lost or duplicated, order is preserved.
- Reset mid-stream: drive rst = 0 with 2 windows in flight → out_valid = 0 at once. After release, no stale output appears and the next window emerges with latency 3.
